rounding_unit_pipelined: RTL and testbench
==========================================

// Module: rounding_unit_pipelined
// PURPOSE
//  Parametrised, pipelined IEEE-754 fraction rounder placed after the normaliser in every FPU datapath.
//  Takes a normalised fraction [xx.xxx...] split into KEEP_W kept bits and DROP_W discarded bits.
//  Applies one of the IEEE rounding modes chosen per operation, and reports carry-out and inexact.
//  Two register stages with valid/ready flow control; the whole pipe stalls under backpressure.
// PARAMETERS
//  KEEP_W  32  kept fraction bits incl. 2 integer bits (LSB of result = in_fraction[DROP_W])
//  DROP_W  17  discarded bits below LSB, must be >=2 (guard = [DROP_W-1], round = [DROP_W-2])
// PORTS
//  clk            in   1              sole clock, rising edge
//  reset          in   1              synchronous, active-high
//  in_valid       in   1              input beat valid
//  in_ready       out  1              unit accepts beat this cycle
//  in_sign        in   1              sign of result (used by RDN/RUP)
//  in_mode        in   3              0=RNE 1=RTZ 2=RDN 3=RUP 4=RMM, 5-7 reserved
//  in_sticky      in   1              sticky from upstream alignment shifter
//  in_fraction    in   KEEP_W+DROP_W  normalised fraction, 2 integer bits
//  out_valid      out  1              result valid
//  out_ready      in   1              downstream accepts result
//  out_fraction   out  KEEP_W         rounded fraction, 2 integer bits (wraps on carry)
//  out_carry      out  1              increment overflowed KEEP_W bits; downstream renormalises
//  out_inexact    out  1              guard|round|sticky was nonzero
// BEHAVIOUR
//  - Reset: out_valid=0, out_fraction=0, out_carry=0, out_inexact=0, all stage valids=0; in_ready=0 while reset high.
//  - sticky S = in_sticky | OR(in_fraction[DROP_W-3:0]) (only in_sticky when DROP_W==2); L = in_fraction[DROP_W]; G, R as above.
//  - increment: RNE G&(L|R|S); RTZ 0; RDN sign&(G|R|S); RUP !sign&(G|R|S); RMM G.
//  - Reserved modes 5-7 behave exactly as RNE. inexact = G|R|S regardless of mode.
//  - Stage 1 registers kept bits, increment, inexact. Stage 2 performs KEEP_W+1-bit add.
//  - Stage 2 registers sum[KEEP_W-1:0] into out_fraction and sum[KEEP_W] into out_carry.
//  - advance = !out_valid | out_ready; in_ready = advance & !reset. Both stages load only when advance.
//  - Latency 2 cycles, throughput 1/cycle when out_ready held high.
//  - Backpressure: with out_ready=0 and both stages full, in_ready=0; outputs held stable, no beat lost or reordered.
//  - Bubbles: stage valid propagates 0; the data registers of a bubble hold their previous value.
//  - Reset mid-operation discards all in-flight beats; first accepted beat after reset appears 2 cycles later.
// CONFIGURATION
//  ROUNDING_UNIT_RMM_EN defined: mode 4 = round-to-nearest, ties-away (increment = G).
//  ROUNDING_UNIT_RMM_EN undefined: mode 4 is reserved and behaves as RNE; no RMM logic synthesised.
// STRUCTURE
//  fpu_rounding_pkg: rounding_mode_t enum (RNE/RTZ/RDN/RUP/RMM, 3-bit), mode encodings shared with decoder.
//  Sub-module rounding_increment_decider: combinational L/G/R/S + mode + sign -> increment, inexact.
//  Top holds both pipeline stages, the adder and the handshake.
// TESTING  (KEEP_W=32, DROP_W=17; "keep"/"drop" = in_fraction upper/lower fields)
//  RNE tie-even: keep=0x4000_0000 drop=0x10000 sticky=0 -> out 0x4000_0000, inexact=1; keep=0x4000_0001 -> 0x4000_0002.
//  Directed modes: keep=0x4000_0000 drop=0x00001 sign=0 -> RUP 0x4000_0001, RDN/RTZ/RNE 0x4000_0000, all inexact=1.
//  Sign/mode: same input with sign=1 -> RDN 0x4000_0001, RUP 0x4000_0000; RMM drop=0x10000 -> 0x4000_0001 only if RMM_EN.
//  Exact/carry: drop=0, sticky=0 -> inexact=0, unchanged; keep=0xFFFF_FFFF drop=0x18000 RNE -> out 0, out_carry=1.
//  Backpressure: 4 back-to-back beats, out_ready=0 for 3 cycles -> in_ready=0 after 2 accepted; all 4 emerge in order.
//  Reset: assert reset with 2 beats in flight -> out_valid=0 next cycle, no stale beat emitted after release.

Source files
------------

// File: rtl/fpu_rounding_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : fpu_rounding_pkg                                       |
// | Description : Rounding-mode encodings shared by the FPU decoder and  |
// |               the rounding unit.                                     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package fpu_rounding_pkg;

    // Encodings 5-7 are reserved and are treated as RNE by consumers.
    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rounding_mode_t;

endpackage
`default_nettype wire

// File: rtl/rounding_increment_decider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rounding_increment_decider                             |
// | Description : Combinational rounding decision from L/G/R/S, mode and |
// |               sign. Produces the increment request and inexact flag. |
// |               Define ROUNDING_UNIT_RMM_EN to enable ties-away (mode  |
// |               4); otherwise mode 4 rounds like RNE.                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rounding_increment_decider
    import fpu_rounding_pkg::*;
(
    input  logic       lsb,
    input  logic       guard,
    input  logic       round_bit,
    input  logic       sticky,
    input  logic       sign,
    input  logic [2:0] mode,
    output logic       increment,
    output logic       inexact
);

    logic w_any_dropped;

    assign w_any_dropped = guard | round_bit | sticky;
    assign inexact       = w_any_dropped;

    // Mode-dependent increment; anything not listed (reserved codes) rounds as RNE.
    always_comb begin
        increment = guard & (lsb | round_bit | sticky);
        case (rounding_mode_t'(mode))
            RM_RTZ: increment = 1'b0;
            RM_RDN: increment = sign & w_any_dropped;
            RM_RUP: increment = !sign & w_any_dropped;
`ifdef ROUNDING_UNIT_RMM_EN
            RM_RMM: increment = guard;
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rounding_unit_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : rounding_unit_pipelined                                |
// | Description : Two-stage IEEE-754 fraction rounder with valid/ready   |
// |               flow control. Stage 1 captures the kept bits and the   |
// |               rounding decision, stage 2 applies the increment.      |
// |               Optional macro ROUNDING_UNIT_RMM_EN enables mode 4     |
// |               (round-to-nearest, ties-away).                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module rounding_unit_pipelined
    import fpu_rounding_pkg::*;
#(
    parameter int KEEP_W = 32,
    parameter int DROP_W = 17
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [2:0]               in_mode,
    input  logic                     in_sticky,
    input  logic [KEEP_W+DROP_W-1:0] in_fraction,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [KEEP_W-1:0]        out_fraction,
    output logic                     out_carry,
    output logic                     out_inexact
);

    localparam int FRAC_W = KEEP_W + DROP_W;

    logic              w_lsb;
    logic              w_guard;
    logic              w_round;
    logic              w_sticky;
    logic              w_increment;
    logic              w_inexact;
    logic              w_advance;
    logic [KEEP_W:0]   w_sum;

    logic              r_s1_valid;
    logic [KEEP_W-1:0] r_s1_keep;
    logic              r_s1_increment;
    logic              r_s1_inexact;

    logic              r_out_valid;
    logic [KEEP_W-1:0] r_out_fraction;
    logic              r_out_carry;
    logic              r_out_inexact;

    assign w_lsb   = in_fraction[DROP_W];
    assign w_guard = in_fraction[DROP_W-1];
    assign w_round = in_fraction[DROP_W-2];

    // Bits below the round position fold into sticky; with DROP_W==2 there are none.
    generate
        if (DROP_W > 2) begin : g_sticky_wide
            assign w_sticky = in_sticky | (|in_fraction[DROP_W-3:0]);
        end else begin : g_sticky_narrow
            assign w_sticky = in_sticky;
        end
    endgenerate

    rounding_increment_decider u_decider (
        .lsb       (w_lsb),
        .guard     (w_guard),
        .round_bit (w_round),
        .sticky    (w_sticky),
        .sign      (in_sign),
        .mode      (in_mode),
        .increment (w_increment),
        .inexact   (w_inexact)
    );

    // The whole pipe moves together: it advances whenever the output slot is free or drained.
    assign w_advance = !r_out_valid | out_ready;
    assign in_ready  = w_advance & !reset;

    // Stage 1: capture kept bits and rounding decision; bubbles keep old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid     <= 1'b0;
            r_s1_keep      <= '0;
            r_s1_increment <= 1'b0;
            r_s1_inexact   <= 1'b0;
        end else if (w_advance) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_keep      <= in_fraction[FRAC_W-1:DROP_W];
                r_s1_increment <= w_increment;
                r_s1_inexact   <= w_inexact;
            end
        end
    end

    // One extra bit on the adder exposes the carry out of the kept field.
    assign w_sum = {1'b0, r_s1_keep} + (KEEP_W+1)'(r_s1_increment);

    // Stage 2: register the rounded result; bubbles keep old data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid    <= 1'b0;
            r_out_fraction <= '0;
            r_out_carry    <= 1'b0;
            r_out_inexact  <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_fraction <= w_sum[KEEP_W-1:0];
                r_out_carry    <= w_sum[KEEP_W];
                r_out_inexact  <= r_s1_inexact;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_fraction = r_out_fraction;
    assign out_carry    = r_out_carry;
    assign out_inexact  = r_out_inexact;

endmodule
`default_nettype wire

// File: tb/tb_rounding_unit_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_rounding_unit_pipelined                             |
// | Description : Directed self-checking bench for the rounding unit     |
// |               (KEEP_W=32, DROP_W=17). Honours ROUNDING_UNIT_RMM_EN.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_rounding_unit_pipelined;

    localparam int KEEP_W = 32;
    localparam int DROP_W = 17;
`ifdef ROUNDING_UNIT_RMM_EN
    localparam logic [31:0] RMM_TIE_EXP = 32'h4000_0001;
`else
    localparam logic [31:0] RMM_TIE_EXP = 32'h4000_0000;
`endif

    typedef struct packed {
        logic [31:0] keep;
        logic [16:0] drop;
        logic        sticky;
        logic        sign;
        logic [2:0]  mode;
        logic [31:0] exp_frac;
        logic        exp_carry;
        logic        exp_inexact;
    } vec_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_sign;
    logic [2:0]               in_mode;
    logic                     in_sticky;
    logic [KEEP_W+DROP_W-1:0] in_fraction;
    logic                     out_valid;
    logic                     out_ready;
    logic [KEEP_W-1:0]        out_fraction;
    logic                     out_carry;
    logic                     out_inexact;

    int n_cmp = 0;
    int n_err = 0;

    rounding_unit_pipelined #(.KEEP_W(KEEP_W), .DROP_W(DROP_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_mode      (in_mode),
        .in_sticky    (in_sticky),
        .in_fraction  (in_fraction),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_fraction (out_fraction),
        .out_carry    (out_carry),
        .out_inexact  (out_inexact)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [31:0] keep, input logic [16:0] drop,
                                input logic sticky, input logic sign, input logic [2:0] mode,
                                input logic [31:0] ef, input logic ec, input logic ex);
        vec_t v;
        v.keep = keep; v.drop = drop; v.sticky = sticky; v.sign = sign; v.mode = mode;
        v.exp_frac = ef; v.exp_carry = ec; v.exp_inexact = ex;
        return v;
    endfunction

    // Caller is at posedge+1; leaves the bench at posedge+1 two edges later.
    task automatic run_beat(input vec_t v, output logic [31:0] f, output logic c,
                            output logic x, output logic vld);
        in_valid    = 1'b1;
        in_fraction = {v.keep, v.drop};
        in_sticky   = v.sticky;
        in_sign     = v.sign;
        in_mode     = v.mode;
        out_ready   = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        f = out_fraction; c = out_carry; x = out_inexact; vld = out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_fraction = '0; in_sticky = 1'b0; in_sign = 1'b0; in_mode = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        n_cmp++;
        if (out_fraction !== 32'h0) begin n_err++; $display("FAIL reset_out_fraction got=%h want=0", out_fraction); end
        n_cmp++;
        if ({out_carry, out_inexact} !== 2'b00) begin
            n_err++; $display("FAIL reset_flags got carry=%b inexact=%b want 0/0", out_carry, out_inexact);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_modes();
        vec_t q[$];
        logic [31:0] f;
        logic c, x, vld;
        q.push_back(mk(32'h4000_0000, 17'h10000, 0, 0, 3'd0, 32'h4000_0000, 0, 1)); // RNE tie, even
        q.push_back(mk(32'h4000_0001, 17'h10000, 0, 0, 3'd0, 32'h4000_0002, 0, 1)); // RNE tie, odd
        q.push_back(mk(32'h4000_0000, 17'h00001, 0, 0, 3'd3, 32'h4000_0001, 0, 1)); // RUP +
        q.push_back(mk(32'h4000_0000, 17'h00001, 0, 0, 3'd2, 32'h4000_0000, 0, 1)); // RDN +
        q.push_back(mk(32'h4000_0000, 17'h00001, 0, 0, 3'd1, 32'h4000_0000, 0, 1)); // RTZ +
        q.push_back(mk(32'h4000_0000, 17'h00001, 0, 0, 3'd0, 32'h4000_0000, 0, 1)); // RNE sticky only
        q.push_back(mk(32'h4000_0000, 17'h00001, 0, 1, 3'd2, 32'h4000_0001, 0, 1)); // RDN -
        q.push_back(mk(32'h4000_0000, 17'h00001, 0, 1, 3'd3, 32'h4000_0000, 0, 1)); // RUP -
        q.push_back(mk(32'h4000_0000, 17'h10000, 0, 0, 3'd4, RMM_TIE_EXP,   0, 1)); // RMM tie
        q.push_back(mk(32'h4000_0001, 17'h10000, 0, 0, 3'd5, 32'h4000_0002, 0, 1)); // reserved -> RNE
        q.push_back(mk(32'h4000_0000, 17'h10000, 0, 0, 3'd7, 32'h4000_0000, 0, 1)); // reserved -> RNE
        q.push_back(mk(32'h1234_5678, 17'h00000, 0, 0, 3'd3, 32'h1234_5678, 0, 0)); // exact
        q.push_back(mk(32'h1234_5678, 17'h00000, 1, 0, 3'd3, 32'h1234_5679, 0, 1)); // upstream sticky
        q.push_back(mk(32'hFFFF_FFFF, 17'h18000, 0, 0, 3'd0, 32'h0000_0000, 1, 1)); // carry out
        q.push_back(mk(32'h4000_0000, 17'h08000, 0, 0, 3'd0, 32'h4000_0000, 0, 1)); // round bit only
        q.push_back(mk(32'h4000_0000, 17'h18000, 0, 0, 3'd0, 32'h4000_0001, 0, 1)); // above half
        q.push_back(mk(32'h7FFF_FFFF, 17'h1FFFF, 0, 0, 3'd1, 32'h7FFF_FFFF, 0, 1)); // RTZ truncates
        foreach (q[i]) begin
            run_beat(q[i], f, c, x, vld);
            n_cmp++;
            if (vld !== 1'b1) begin n_err++; $display("FAIL mode_vec%0d_valid got=%b want=1", i, vld); end
            n_cmp++;
            if (f !== q[i].exp_frac) begin
                n_err++; $display("FAIL mode_vec%0d_fraction got=%h want=%h", i, f, q[i].exp_frac);
            end
            n_cmp++;
            if (c !== q[i].exp_carry) begin
                n_err++; $display("FAIL mode_vec%0d_carry got=%b want=%b", i, c, q[i].exp_carry);
            end
            n_cmp++;
            if (x !== q[i].exp_inexact) begin
                n_err++; $display("FAIL mode_vec%0d_inexact got=%b want=%b", i, x, q[i].exp_inexact);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [31:0] keep [4];
        logic [31:0] exp_f [4];
        logic        exp_x [4];
        int acc = 0;
        int got = 0;
        logic rdy;
        for (int i = 0; i < 4; i++) begin
            keep[i]  = 32'h1000_0000 + 32'(i) * 32'h11;
            exp_f[i] = keep[i] + ((i % 2 == 1) ? 32'd1 : 32'd0);
            exp_x[i] = (i % 2 == 1);
        end
        in_sticky = 1'b0; in_sign = 1'b0; in_mode = 3'd0;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            out_ready = (cyc >= 5);
            if (acc < 4) begin
                in_valid    = 1'b1;
                in_fraction = {keep[acc], (acc % 2 == 1) ? 17'h18000 : 17'h00000};
            end else begin
                in_valid = 1'b0;
            end
            #1;
            rdy = in_ready;
            if (cyc >= 2 && cyc <= 4) begin
                n_cmp++;
                if (rdy !== 1'b0 || acc != 2) begin
                    n_err++; $display("FAIL bp_stall_cyc%0d in_ready=%b accepted=%0d want 0/2", cyc, rdy, acc);
                end
                n_cmp++;
                if (out_valid !== 1'b1 || out_fraction !== exp_f[0]) begin
                    n_err++; $display("FAIL bp_hold_cyc%0d valid=%b frac=%h want 1/%h", cyc, out_valid, out_fraction, exp_f[0]);
                end
            end
            if (out_valid === 1'b1 && out_ready) begin
                n_cmp++;
                if (out_fraction !== exp_f[got] || out_inexact !== exp_x[got] || out_carry !== 1'b0) begin
                    n_err++; $display("FAIL bp_order_beat%0d frac=%h inexact=%b carry=%b want %h/%b/0",
                                      got, out_fraction, out_inexact, out_carry, exp_f[got], exp_x[got]);
                end
                got++;
            end
            if (in_valid && rdy) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got != 4) begin n_err++; $display("FAIL bp_drain got=%0d beats want=4 (timeout)", got); end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_flight();
        out_ready = 1'b1; in_sticky = 1'b0; in_sign = 1'b0; in_mode = 3'd0;
        in_valid = 1'b1; in_fraction = {32'h0AAA_0000, 17'h0};
        @(posedge clk); #1;
        in_fraction = {32'h0BBB_0000, 17'h0};
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid got=%b want=1", out_valid); end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_flush_valid got=%b want=0", out_valid); end
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_stale_cyc%0d got=%b want=0", k, out_valid); end
        end
        in_valid = 1'b1; in_fraction = {32'h0CCC_0000, 17'h10000}; in_mode = 3'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_latency1 got=%b want=0", out_valid); end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_fraction !== 32'h0CCC_0001 || out_inexact !== 1'b1) begin
            n_err++; $display("FAIL rst_first_beat valid=%b frac=%h inexact=%b want 1/0ccc0001/1",
                              out_valid, out_fraction, out_inexact);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_backpressure();
        test_reset_mid_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
